pdm_decimator: RTL and testbench

//  Receive end of the 1-bit PDM link driven by pdm_dac: converts a PDM bitstream
//  (external PDM mic, or loopback of a pdm_dac output) into signed PCM samples.

---
 rtl/pdm_decimator_pkg.sv | 36 +++
 rtl/pdm_decimator_comb.sv | 40 ++++
 rtl/pdm_decimator.sv | 172 +++++++++++++++++
 tb/tb_pdm_decimator.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/pdm_decimator_pkg.sv
// rtl/pdm_decimator_pkg.sv - shared CIC constants, fill FSM states and saturation helper
package pdm_decimator_pkg;

   localparam int CIC_ORDER          = 3;
   localparam int PCM_BITS_DEFAULT   = 12;
   localparam int DECIM_LOG2_DEFAULT = 8;
   localparam int ACC_BITS_DEFAULT   = 28;

   // Ticks seen since reset; the first three only prime the comb delays
   typedef enum logic [1:0] {
      FILL_0,
      FILL_1,
      FILL_2,
      FILL_RUN
   } fill_state_e;

   function automatic int cic_gain_log2(input int decim_log2);
      return CIC_ORDER * decim_log2;
   endfunction

   // Clamp a signed value into the range of a signed word of the given width
   function automatic longint sat_clip(input longint v, input int bits);
      longint hi;
      longint lo;
      hi = (64'sd1 <<< (bits - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (bits - 1));
      if (v > hi) begin
         return hi;
      end
      if (v < lo) begin
         return lo;
      end
      return v;
   endfunction

endpackage

// File: rtl/pdm_decimator_comb.sv
// rtl/pdm_decimator_comb.sv - one registered CIC comb stage, y = x - x_prev at the decimated rate
module cic_comb_stage
   import pdm_decimator_pkg::*;
#(
   parameter int ACC_BITS = ACC_BITS_DEFAULT
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en_i,
   input  logic [ACC_BITS-1:0] x_i,
   output logic [ACC_BITS-1:0] y_o
);

   logic [ACC_BITS-1:0] prev_q;
   logic [ACC_BITS-1:0] prev_d;
   logic [ACC_BITS-1:0] y_q;
   logic [ACC_BITS-1:0] y_d;

   always_comb begin
      prev_d = prev_q;
      y_d    = y_q;
      if (en_i) begin
         prev_d = x_i;
         y_d    = x_i - prev_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prev_q <= '0;
         y_q    <= '0;
      end else begin
         prev_q <= prev_d;
         y_q    <= y_d;
      end
   end

   assign y_o = y_q;

endmodule

// File: rtl/pdm_decimator.sv
// rtl/pdm_decimator.sv - 3rd-order CIC decimator turning a 1-bit PDM stream into saturated signed PCM
module pdm_decimator
   import pdm_decimator_pkg::*;
#(
   parameter int DATA_BITS  = PCM_BITS_DEFAULT,
   parameter int DECIM_LOG2 = DECIM_LOG2_DEFAULT,
   parameter int ACC_BITS   = ACC_BITS_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 pdm_en,
   input  logic                 din,
   output logic [DATA_BITS-1:0] dout,
   output logic                 dout_valid
);

   localparam int SHIFT = cic_gain_log2(DECIM_LOG2) - (DATA_BITS - 1);

   // The comb pipeline is 4 clk deep, so ticks closer than that would collide
   if (DECIM_LOG2 < 2) begin : g_chk_ratio
      $error("pdm_decimator: DECIM_LOG2 must be at least 2");
   end
   if (ACC_BITS < cic_gain_log2(DECIM_LOG2) + 2) begin : g_chk_acc
      $error("pdm_decimator: ACC_BITS too small for the CIC gain");
   end
   if (SHIFT < 0) begin : g_chk_shift
      $error("pdm_decimator: DATA_BITS wider than the CIC gain");
   end

   logic                        sync1_q;
   logic                        sync2_q;
   logic signed [ACC_BITS-1:0]  x_in;

   logic signed [ACC_BITS-1:0]  i1_q;
   logic signed [ACC_BITS-1:0]  i1_d;
   logic signed [ACC_BITS-1:0]  i2_q;
   logic signed [ACC_BITS-1:0]  i2_d;
   logic signed [ACC_BITS-1:0]  i3_q;
   logic signed [ACC_BITS-1:0]  i3_d;

   logic [DECIM_LOG2-1:0]       cnt_q;
   logic [DECIM_LOG2-1:0]       cnt_d;
   logic                        tick_q;
   logic                        tick_d;

   fill_state_e                 fill_q;
   fill_state_e                 fill_d;
   logic                        emit_now;

   logic [2:0]                  pipe_q;
   logic [2:0]                  pipe_d;
   logic [2:0]                  emit_q;
   logic [2:0]                  emit_d;

   logic [ACC_BITS-1:0]         c1_y;
   logic [ACC_BITS-1:0]         c2_y;
   logic [ACC_BITS-1:0]         c3_y;
   logic signed [ACC_BITS-1:0]  c3_s;
   logic signed [ACC_BITS-1:0]  scaled;

   logic [DATA_BITS-1:0]        dout_q;
   logic [DATA_BITS-1:0]        dout_d;
   logic                        valid_q;
   logic                        valid_d;

   // Synced bit maps to +1 / -1
   assign x_in = sync2_q ? ACC_BITS'(1) : '1;

   always_comb begin
      i1_d   = i1_q;
      i2_d   = i2_q;
      i3_d   = i3_q;
      cnt_d  = cnt_q;
      tick_d = 1'b0;
      if (pdm_en) begin
         i1_d   = i1_q + x_in;
         i2_d   = i2_q + i1_q;
         i3_d   = i3_q + i2_q;
         cnt_d  = cnt_q + DECIM_LOG2'(1);
         tick_d = &cnt_q;
      end
   end

   always_comb begin
      fill_d   = fill_q;
      emit_now = 1'b0;
      if (tick_q) begin
         case (fill_q)
            FILL_0:  fill_d = FILL_1;
            FILL_1:  fill_d = FILL_2;
            FILL_2:  fill_d = FILL_RUN;
            default: begin
               fill_d   = FILL_RUN;
               emit_now = 1'b1;
            end
         endcase
      end
   end

   // Strobes for comb stages 2, 3 and the output register; independent of pdm_en
   assign pipe_d = {pipe_q[1:0], tick_q};
   assign emit_d = {emit_q[1:0], emit_now};

   cic_comb_stage #(.ACC_BITS(ACC_BITS)) u_comb1 (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  (tick_q),
      .x_i   (i3_q),
      .y_o   (c1_y)
   );

   cic_comb_stage #(.ACC_BITS(ACC_BITS)) u_comb2 (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  (pipe_q[0]),
      .x_i   (c1_y),
      .y_o   (c2_y)
   );

   cic_comb_stage #(.ACC_BITS(ACC_BITS)) u_comb3 (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  (pipe_q[1]),
      .x_i   (c2_y),
      .y_o   (c3_y)
   );

   assign c3_s   = $signed(c3_y);
   assign scaled = c3_s >>> SHIFT;

   always_comb begin
      dout_d  = dout_q;
      valid_d = emit_q[2];
      if (emit_q[2]) begin
         dout_d = DATA_BITS'(sat_clip(longint'(scaled), DATA_BITS));
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         i1_q    <= '0;
         i2_q    <= '0;
         i3_q    <= '0;
         cnt_q   <= '0;
         tick_q  <= 1'b0;
         fill_q  <= FILL_0;
         pipe_q  <= '0;
         emit_q  <= '0;
         dout_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         sync1_q <= din;
         sync2_q <= sync1_q;
         i1_q    <= i1_d;
         i2_q    <= i2_d;
         i3_q    <= i3_d;
         cnt_q   <= cnt_d;
         tick_q  <= tick_d;
         fill_q  <= fill_d;
         pipe_q  <= pipe_d;
         emit_q  <= emit_d;
         dout_q  <= dout_d;
         valid_q <= valid_d;
      end
   end

   assign dout       = dout_q;
   assign dout_valid = valid_q;

endmodule

// File: tb/tb_pdm_decimator.sv
// tb/tb_pdm_decimator.sv - directed vector bench for the PDM CIC decimator
module tb_pdm_decimator;

   localparam int DB = 12;
   localparam int R  = 256;

   logic          clk    = 1'b0;
   logic          rst_n  = 1'b0;
   logic          pdm_en = 1'b0;
   logic          din    = 1'b0;
   logic [DB-1:0] dout;
   logic          dout_valid;

   always #5 clk = ~clk;

   pdm_decimator #(.DATA_BITS(DB), .DECIM_LOG2(8), .ACC_BITS(28)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .pdm_en     (pdm_en),
      .din        (din),
      .dout       (dout),
      .dout_valid (dout_valid)
   );

   int n_cmp    = 0;
   int n_bad    = 0;
   int hold_err = 0;

   // Stimulus source: 0 = repeating pattern, 1 = second-order sigma-delta DAC model, 2 = pdm_en held low
   int         mode     = 0;
   logic [7:0] pat      = 8'h01;
   int         pat_len  = 1;
   int         en_div   = 1;
   int         phase    = 0;
   int         en_ph    = 0;
   int         sd_level = 0;
   int         sd_v1    = 0;
   int         sd_v2    = 0;

   initial forever begin
      @(negedge clk);
      if (mode == 2) begin
         pdm_en = 1'b0;
      end else begin
         pdm_en = (en_ph == 0);
         en_ph  = (en_ph + 1) % en_div;
      end
      if (pdm_en) begin
         if (mode == 1) begin
            int yfb;
            din   = (sd_v2 >= 0);
            yfb   = din ? 2048 : -2048;
            sd_v1 = sd_v1 + sd_level - yfb;
            sd_v2 = sd_v2 + sd_v1 - yfb;
         end else begin
            din   = pat[phase];
            phase = (phase + 1) % pat_len;
         end
      end
   end

   function automatic int sval(input logic [DB-1:0] v);
      return int'($signed(v));
   endfunction

   task automatic chk(input string nm, input int act, input int exp, input int tol);
      n_cmp++;
      if (act < exp - tol || act > exp + tol) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (tol %0d)", nm, act, exp, tol);
      end
   endtask

   task automatic wait_valid(input int budget, output int cyc, output bit ok);
      logic [DB-1:0] prev;
      prev = dout;
      cyc  = 0;
      ok   = 1'b0;
      while (!ok && cyc < budget) begin
         @(posedge clk);
         #1;
         cyc++;
         if (dout_valid) begin
            ok = 1'b1;
         end else if (dout !== prev) begin
            hold_err++;
         end
      end
   endtask

   task automatic do_reset(input int m, input logic [7:0] p, input int len, input int div);
      @(negedge clk);
      rst_n   = 1'b0;
      mode    = m;
      pat     = p;
      pat_len = len;
      en_div  = div;
      phase   = 0;
      en_ph   = 0;
      sd_v1   = 0;
      sd_v2   = 0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic [7:0] pat;
      int         len;
      int         div;
      int         exp;
      int         tol;
   } vec_t;

   vec_t vt[6];
   int   levels[3];

   initial begin
      int cyc;
      bit ok;
      int h0;

      vt[0] = '{8'h01, 1, 1,  2047, 0};
      vt[1] = '{8'h00, 1, 1, -2048, 0};
      vt[2] = '{8'h01, 2, 1,     0, 1};
      vt[3] = '{8'h07, 4, 1,  1024, 1};
      vt[4] = '{8'h01, 4, 1, -1024, 1};
      vt[5] = '{8'h01, 1, 4,  2047, 0};
      levels[0] = 500;
      levels[1] = -1500;
      levels[2] = 0;

      rst_n = 1'b0;
      din   = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_dout", sval(dout), 0, 0);
      chk("reset_valid", int'(dout_valid), 0, 0);

      for (int r = 0; r < 6; r++) begin
         do_reset(0, vt[r].pat, vt[r].len, vt[r].div);
         h0 = hold_err;
         wait_valid(4500 * vt[r].div, cyc, ok);
         chk($sformatf("row%0d_first_valid", r), int'(ok), 1, 0);
         if (vt[r].div == 1) begin
            chk($sformatf("row%0d_fill_latency", r), cyc, 1028, 0);
         end
         for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("row%0d_pulse_width", r), int'(dout_valid), 0, 0);
            wait_valid(R * vt[r].div + 8, cyc, ok);
            chk($sformatf("row%0d_period", r), cyc + 1, R * vt[r].div, 0);
            chk($sformatf("row%0d_value", r), sval(dout), vt[r].exp, vt[r].tol);
         end
         chk($sformatf("row%0d_hold", r), hold_err - h0, 0, 0);
      end

      mode = 2;
      h0   = hold_err;
      wait_valid(2000, cyc, ok);
      chk("freeze_no_valid", int'(ok), 0, 0);
      chk("freeze_hold", hold_err - h0, 0, 0);
      mode = 0;
      wait_valid(4400, cyc, ok);
      chk("resume_valid", int'(ok), 1, 0);
      chk("resume_value", sval(dout), 2047, 0);

      do_reset(0, 8'h07, 4, 1);
      wait_valid(1100, cyc, ok);
      wait_valid(300, cyc, ok);
      chk("midrst_pre_value", sval(dout), 1024, 1);
      repeat (100) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("midrst_dout", sval(dout), 0, 0);
      chk("midrst_valid", int'(dout_valid), 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      wait_valid(1200, cyc, ok);
      chk("midrst_latency", cyc, 1028, 0);
      chk("midrst_value", sval(dout), 1024, 1);

      sd_level = levels[0];
      do_reset(1, 8'h00, 1, 1);
      for (int l = 0; l < 3; l++) begin
         sd_level = levels[l];
         for (int s = 0; s < 4; s++) begin
            wait_valid(1100, cyc, ok);
         end
         for (int s = 0; s < 64; s++) begin
            wait_valid(300, cyc, ok);
            chk($sformatf("loop%0d_valid", levels[l]), int'(ok), 1, 0);
            chk($sformatf("loop%0d_level", levels[l]), sval(dout), levels[l], 4);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
